// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared constants for the simple CPU control step sequencer
package cpu_pkg;

  localparam int STEP_W_DEF   = 4;
  localparam int MAX_STEP_DEF = 9;
  localparam int IR_W_DEF     = 9;

  typedef logic state_t;
  localparam state_t IDLE = 1'b0;
  localparam state_t EXEC = 1'b1;

  // Step numbers as seen by the control unit (T0 is the idle step)
  localparam logic [STEP_W_DEF-1:0] T0 = 4'd0;
  localparam logic [STEP_W_DEF-1:0] T1 = 4'd1;
  localparam logic [STEP_W_DEF-1:0] T2 = 4'd2;
  localparam logic [STEP_W_DEF-1:0] T3 = 4'd3;
  localparam logic [STEP_W_DEF-1:0] T4 = 4'd4;
  localparam logic [STEP_W_DEF-1:0] T5 = 4'd5;
  localparam logic [STEP_W_DEF-1:0] T6 = 4'd6;
  localparam logic [STEP_W_DEF-1:0] T7 = 4'd7;
  localparam logic [STEP_W_DEF-1:0] T8 = 4'd8;
  localparam logic [STEP_W_DEF-1:0] T9 = 4'd9;

endpackage

// File: rtl/cpu_step_sequencer_if.sv
// rtl/cpu_step_sequencer_if.sv - control/status bundle between control unit and step sequencer
interface cpu_step_sequencer_if
  import cpu_pkg::*;
#(
  parameter int STEP_W = STEP_W_DEF,
  parameter int IR_W   = IR_W_DEF
);

  logic              run;
  logic [IR_W-1:0]   din;
  logic              stall;
  logic              done;
  logic              clear_err;
  logic [STEP_W-1:0] step;
  logic [IR_W-1:0]   ir;
  logic              busy;
  logic              fetch;
  logic              timeout;

  modport master (
    output run, din, stall, done, clear_err,
    input  step, ir, busy, fetch, timeout
  );

  modport slave (
    input  run, din, stall, done, clear_err,
    output step, ir, busy, fetch, timeout
  );

endinterface

// File: rtl/cpu_step_sequencer.sv
// rtl/cpu_step_sequencer.sv - latches an instruction on run and walks control steps 1..MAX_STEP
module cpu_step_sequencer
  import cpu_pkg::*;
#(
  parameter int STEP_W   = STEP_W_DEF,
  parameter int MAX_STEP = MAX_STEP_DEF,
  parameter int IR_W     = IR_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  cpu_step_sequencer_if.slave  bus
);

  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(MAX_STEP);
  localparam logic [STEP_W-1:0] ONE       = STEP_W'(1);

  state_t            state, state_next;
  logic [STEP_W-1:0] step_q, step_next;
  logic [IR_W-1:0]   ir_q, ir_next;
  logic              fetch_q, fetch_next;
  logic              timeout_q, timeout_next;
  logic              timeout_set;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (bus.run) state_next = EXEC;
      EXEC: begin
        if (bus.done)                          state_next = IDLE;
        else if (!bus.stall && step_q == LAST_STEP) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Next values of the registered outputs; done beats stall, stall beats the step limit
  always_comb begin
    step_next   = step_q;
    ir_next     = ir_q;
    fetch_next  = 1'b0;
    timeout_set = 1'b0;
    case (state)
      IDLE: begin
        step_next = '0;
        if (bus.run) begin
          step_next  = ONE;
          ir_next    = bus.din;
          fetch_next = 1'b1;
        end
      end
      EXEC: begin
        if (bus.done) begin
          step_next = '0;
        end else if (bus.stall) begin
          step_next = step_q;
        end else if (step_q == LAST_STEP) begin
          step_next   = '0;
          timeout_set = 1'b1;
        end else begin
          step_next = step_q + ONE;
        end
      end
      default: step_next = '0;
    endcase
    timeout_next = timeout_set | (timeout_q & ~bus.clear_err);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      step_q    <= '0;
      ir_q      <= '0;
      fetch_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      step_q    <= step_next;
      ir_q      <= ir_next;
      fetch_q   <= fetch_next;
      timeout_q <= timeout_next;
    end
  end

  assign bus.step    = step_q;
  assign bus.ir      = ir_q;
  assign bus.busy    = (state == EXEC);
  assign bus.fetch   = fetch_q;
  assign bus.timeout = timeout_q;

endmodule

// File: tb/tb_cpu_step_sequencer.sv
// tb/tb_cpu_step_sequencer.sv - vector table, corner sequences and random run against a reference model
module tb_cpu_step_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   passed = 0;

  cpu_step_sequencer_if #(.STEP_W(4), .IR_W(9)) bus ();

  cpu_step_sequencer #(.STEP_W(4), .MAX_STEP(9), .IR_W(9)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       run;
    logic [8:0] din;
    logic       stall;
    logic       done;
    logic [3:0] step;
    logic       busy;
    logic       fetch;
    logic [8:0] ir;
  } vec_t;

  vec_t vecs[19];

  // Reference state, tracked from the behavioural rules
  int m_step;
  int m_busy;
  int m_fetch;
  int m_ir;
  int m_to;

  function automatic vec_t mk(logic run, logic [8:0] din, logic stall, logic done,
                              logic [3:0] step, logic busy, logic fetch, logic [8:0] ir);
    vec_t v;
    v.run = run; v.din = din; v.stall = stall; v.done = done;
    v.step = step; v.busy = busy; v.fetch = fetch; v.ir = ir;
    return v;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic run, input logic [8:0] din, input logic stall,
                       input logic done, input logic clr);
    bus.run = run; bus.din = din; bus.stall = stall; bus.done = done; bus.clear_err = clr;
  endtask

  task automatic check_all(input string tag, input int step, input int busy, input int fetch,
                           input int ir, input int to);
    check({tag, ".step"},    int'(bus.step),    step);
    check({tag, ".busy"},    int'(bus.busy),    busy);
    check({tag, ".fetch"},   int'(bus.fetch),   fetch);
    check({tag, ".ir"},      int'(bus.ir),      ir);
    check({tag, ".timeout"}, int'(bus.timeout), to);
  endtask

  task automatic do_reset();
    drive(1'b0, 9'h0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1 rst = 1'b1;
    #2 rst = 1'b0;
    m_step = 0; m_busy = 0; m_fetch = 0; m_ir = 0; m_to = 0;
  endtask

  task automatic model_edge(input int run, input int din, input int stall, input int done, input int clr);
    int set_to;
    set_to = 0;
    if (m_busy == 0) begin
      m_fetch = 0;
      if (run != 0) begin
        m_busy = 1; m_step = 1; m_ir = din; m_fetch = 1;
      end
    end else begin
      m_fetch = 0;
      if (done != 0) begin
        m_busy = 0; m_step = 0;
      end else if (stall != 0) begin
        m_step = m_step;
      end else if (m_step == 9) begin
        m_busy = 0; m_step = 0; set_to = 1;
      end else begin
        m_step = m_step + 1;
      end
    end
    if (set_to != 0)   m_to = 1;
    else if (clr != 0) m_to = 0;
  endtask

  initial begin
    drive(1'b0, 9'h0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    #12 rst = 1'b0;
    #1;
    check_all("reset", 0, 0, 0, 0, 0);

    // Done at step 3, stall hold at step 2, stall+done, stall on the fetch cycle
    vecs[0]  = mk(1, 9'h1A5, 0, 0, 1, 1, 1, 9'h1A5);
    vecs[1]  = mk(0, 9'h1FF, 0, 0, 2, 1, 0, 9'h1A5);
    vecs[2]  = mk(0, 9'h000, 0, 0, 3, 1, 0, 9'h1A5);
    vecs[3]  = mk(0, 9'h0FF, 0, 1, 0, 0, 0, 9'h1A5);
    vecs[4]  = mk(1, 9'h0F0, 0, 0, 1, 1, 1, 9'h0F0);
    vecs[5]  = mk(0, 9'h1FF, 0, 0, 2, 1, 0, 9'h0F0);
    vecs[6]  = mk(0, 9'h1FF, 1, 0, 2, 1, 0, 9'h0F0);
    vecs[7]  = mk(1, 9'h1FF, 1, 0, 2, 1, 0, 9'h0F0);
    vecs[8]  = mk(0, 9'h1FF, 1, 0, 2, 1, 0, 9'h0F0);
    vecs[9]  = mk(0, 9'h1FF, 1, 0, 2, 1, 0, 9'h0F0);
    vecs[10] = mk(0, 9'h1FF, 0, 0, 3, 1, 0, 9'h0F0);
    vecs[11] = mk(0, 9'h1FF, 0, 1, 0, 0, 0, 9'h0F0);
    vecs[12] = mk(1, 9'h033, 0, 0, 1, 1, 1, 9'h033);
    vecs[13] = mk(0, 9'h1FF, 0, 0, 2, 1, 0, 9'h033);
    vecs[14] = mk(0, 9'h1FF, 1, 1, 0, 0, 0, 9'h033);
    vecs[15] = mk(1, 9'h011, 1, 0, 1, 1, 1, 9'h011);
    vecs[16] = mk(0, 9'h1FF, 1, 0, 1, 1, 0, 9'h011);
    vecs[17] = mk(0, 9'h1FF, 0, 0, 2, 1, 0, 9'h011);
    vecs[18] = mk(0, 9'h1FF, 0, 1, 0, 0, 0, 9'h011);

    for (int i = 0; i < 19; i++) begin
      drive(vecs[i].run, vecs[i].din, vecs[i].stall, vecs[i].done, 1'b0);
      tick();
      check_all($sformatf("vec%0d", i), vecs[i].step, vecs[i].busy, vecs[i].fetch, vecs[i].ir, 0);
    end

    // Runaway instruction: 1..9 then timeout, sticky until clear
    drive(1, 9'h07E, 0, 0, 0);
    tick();
    check("to.first", int'(bus.step), 1);
    drive(0, 9'h000, 0, 0, 0);
    for (int k = 2; k <= 9; k++) begin
      tick();
      check($sformatf("to.step%0d", k), int'(bus.step), k);
    end
    check("to.pre", int'(bus.timeout), 0);
    tick();
    check_all("to.edge", 0, 0, 0, 9'h07E, 1);
    tick();
    check("to.sticky", int'(bus.timeout), 1);
    drive(0, 9'h000, 0, 0, 1);
    tick();
    check("to.clear", int'(bus.timeout), 0);

    // Clear on the timeout edge: set wins
    drive(1, 9'h101, 0, 0, 0);
    tick();
    drive(0, 9'h000, 0, 0, 0);
    for (int k = 2; k <= 9; k++) tick();
    check("to2.step9", int'(bus.step), 9);
    drive(0, 9'h000, 0, 0, 1);
    tick();
    check_all("to2.setwins", 0, 0, 0, 9'h101, 1);

    // Asynchronous reset mid-instruction at step 5
    drive(1, 9'h0C3, 0, 0, 0);
    tick();
    drive(0, 9'h000, 0, 0, 0);
    for (int k = 2; k <= 5; k++) tick();
    check("arst.pre", int'(bus.step), 5);
    rst = 1'b1;
    #1;
    check_all("arst.async", 0, 0, 0, 0, 0);
    #2 rst = 1'b0;
    tick();
    check_all("arst.after", 0, 0, 0, 0, 0);

    // Run held high, done at step 2; din changes during EXEC
    drive(1, 9'h0AA, 0, 0, 0);
    tick();
    check_all("held.s1", 1, 1, 1, 9'h0AA, 0);
    drive(1, 9'h155, 0, 0, 0);
    tick();
    check_all("held.s2", 2, 1, 0, 9'h0AA, 0);
    drive(1, 9'h155, 0, 1, 0);
    tick();
    check_all("held.s0", 0, 0, 0, 9'h0AA, 0);
    drive(1, 9'h155, 0, 0, 0);
    tick();
    check_all("held.s1b", 1, 1, 1, 9'h155, 0);
    drive(0, 9'h000, 0, 1, 0);
    tick();
    check("held.end", int'(bus.step), 0);

    // Done/stall in IDLE are ignored; run+done in IDLE starts
    drive(0, 9'h000, 0, 1, 0);
    tick();
    check("idle.done.step", int'(bus.step), 0);
    check("idle.done.busy", int'(bus.busy), 0);
    drive(0, 9'h000, 1, 0, 0);
    tick();
    check("idle.stall.step", int'(bus.step), 0);
    check("idle.stall.busy", int'(bus.busy), 0);
    drive(1, 9'h0E7, 0, 1, 0);
    tick();
    check_all("idle.rundone", 1, 1, 1, 9'h0E7, 0);
    drive(0, 9'h000, 0, 1, 0);
    tick();

    // Random traffic against the reference model
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      int r_run, r_din, r_stall, r_done, r_clr;
      r_run   = ($urandom_range(0, 1) == 0) ? 1 : 0;
      r_din   = int'($urandom_range(0, 511));
      r_stall = ($urandom_range(0, 3) == 0) ? 1 : 0;
      r_done  = ($urandom_range(0, 9) == 0) ? 1 : 0;
      r_clr   = ($urandom_range(0, 15) == 0) ? 1 : 0;
      drive(r_run[0], r_din[8:0], r_stall[0], r_done[0], r_clr[0]);
      model_edge(r_run, r_din, r_stall, r_done, r_clr);
      tick();
      check_all($sformatf("rnd%0d", n), m_step, m_busy, m_fetch, m_ir, m_to);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
